// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: shared AXI4-Lite master state type, response codes and protection default
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 64
`endif
package axi4lite_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, CLIENT_RSP} mst_state_t;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axi4lite_mem_master.sv
// axi4lite_mem_master: turns single client requests into one AXI4-Lite transaction each, one in flight
module axi4lite_mem_master
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W = `AXI4_ADDR_BITS,
  parameter int DATA_W = `AXI4_DATA_BITS,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              m_axi4lite_aw_valid,
  input  logic              m_axi4lite_aw_ready,
  output logic [ADDR_W-1:0] m_axi4lite_aw_addr,
  output logic [2:0]        m_axi4lite_aw_prot,
  output logic              m_axi4lite_w_valid,
  input  logic              m_axi4lite_w_ready,
  output logic [DATA_W-1:0] m_axi4lite_w_data,
  output logic [STRB_W-1:0] m_axi4lite_w_strb,
  input  logic              m_axi4lite_b_valid,
  output logic              m_axi4lite_b_ready,
  input  logic [1:0]        m_axi4lite_b_resp,
  output logic              m_axi4lite_ar_valid,
  input  logic              m_axi4lite_ar_ready,
  output logic [ADDR_W-1:0] m_axi4lite_ar_addr,
  output logic [2:0]        m_axi4lite_ar_prot,
  input  logic              m_axi4lite_r_valid,
  output logic              m_axi4lite_r_ready,
  input  logic [DATA_W-1:0] m_axi4lite_r_data,
  input  logic [1:0]        m_axi4lite_r_resp
);
  mst_state_t state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic aw_done, w_done;
  logic aw_fire, w_fire;
  assign aw_fire = m_axi4lite_aw_valid & m_axi4lite_aw_ready;
  assign w_fire = m_axi4lite_w_valid & m_axi4lite_w_ready;
  assign m_axi4lite_aw_addr = addr;
  assign m_axi4lite_ar_addr = addr;
  assign m_axi4lite_w_data = wdata;
  assign m_axi4lite_w_strb = wstrb;
  assign m_axi4lite_aw_prot = PROT_DEFAULT;
  assign m_axi4lite_ar_prot = PROT_DEFAULT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      {m_axi4lite_aw_valid, m_axi4lite_w_valid, m_axi4lite_b_ready, m_axi4lite_ar_valid} <= '0;
      {m_axi4lite_r_ready, rsp_valid, rsp_write, aw_done, w_done} <= '0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      rsp_rdata <= '0;
      rsp_resp <= OKAY;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr <= req_addr;
          wdata <= req_wdata;
          wstrb <= req_wstrb;
          req_ready <= 1'b0;
          m_axi4lite_aw_valid <= req_write;
          m_axi4lite_w_valid <= req_write;
          m_axi4lite_ar_valid <= !req_write;
          state <= req_write ? WR_REQ : RD_REQ;
        end
        WR_REQ: begin
          // AW and W complete independently; leave once both have fired in any order
          if (aw_fire) {m_axi4lite_aw_valid, aw_done} <= 2'b01;
          if (w_fire) {m_axi4lite_w_valid, w_done} <= 2'b01;
          if ((aw_done | aw_fire) & (w_done | w_fire)) begin
            {aw_done, w_done} <= 2'b00;
            m_axi4lite_b_ready <= 1'b1;
            state <= WR_RESP;
          end
        end
        WR_RESP: if (m_axi4lite_b_valid) begin
          m_axi4lite_b_ready <= 1'b0;
          rsp_resp <= m_axi4lite_b_resp;
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          state <= CLIENT_RSP;
        end
        RD_REQ: if (m_axi4lite_ar_ready) begin
          m_axi4lite_ar_valid <= 1'b0;
          m_axi4lite_r_ready <= 1'b1;
          state <= RD_RESP;
        end
        RD_RESP: if (m_axi4lite_r_valid) begin
          m_axi4lite_r_ready <= 1'b0;
          rsp_resp <= m_axi4lite_r_resp;
          rsp_write <= 1'b0;
          rsp_rdata <= m_axi4lite_r_data;
          rsp_valid <= 1'b1;
          state <= CLIENT_RSP;
        end
        CLIENT_RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4lite_mem_master.sv
// tb_axi4lite_mem_master: scoreboard bench with a configurable AXI4-Lite slave and a memory reference model
module tb_axi4lite_mem_master;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_addr = 0;
  logic [63:0] req_wdata = 0;
  logic [7:0] req_wstrb = 0;
  logic rsp_valid, rsp_ready, rsp_write;
  logic [63:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] aw_addr, ar_addr;
  logic [2:0] aw_prot, ar_prot;
  logic [63:0] w_data, r_data;
  logic [7:0] w_strb;
  logic [1:0] b_resp, r_resp;

  axi4lite_mem_master #(.ADDR_W(32), .DATA_W(64), .STRB_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .m_axi4lite_aw_valid(aw_valid), .m_axi4lite_aw_ready(aw_ready), .m_axi4lite_aw_addr(aw_addr),
    .m_axi4lite_aw_prot(aw_prot),
    .m_axi4lite_w_valid(w_valid), .m_axi4lite_w_ready(w_ready), .m_axi4lite_w_data(w_data),
    .m_axi4lite_w_strb(w_strb),
    .m_axi4lite_b_valid(b_valid), .m_axi4lite_b_ready(b_ready), .m_axi4lite_b_resp(b_resp),
    .m_axi4lite_ar_valid(ar_valid), .m_axi4lite_ar_ready(ar_ready), .m_axi4lite_ar_addr(ar_addr),
    .m_axi4lite_ar_prot(ar_prot),
    .m_axi4lite_r_valid(r_valid), .m_axi4lite_r_ready(r_ready), .m_axi4lite_r_data(r_data),
    .m_axi4lite_r_resp(r_resp)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] resp_rule(input logic [31:0] a);
    return a[15:12] == 4'hE ? 2'b10 : a[15:12] == 4'hD ? 2'b11 : 2'b00;
  endfunction

  // reference model: word memory with byte strobes, response decided by address region
  typedef struct {logic w; logic [63:0] d; logic [1:0] r;} rsp_t;
  rsp_t exp_q[$];
  logic [63:0] ref_mem [logic [31:0]];
  function automatic rsp_t model(input bit wr, input logic [31:0] a, input logic [63:0] d,
                                 input logic [7:0] s);
    rsp_t e;
    logic [63:0] cur;
    e.w = wr;
    e.r = resp_rule(a);
    e.d = 0;
    cur = ref_mem.exists(a) ? ref_mem[a] : 64'h0;
    if (e.r == 2'b00) begin
      if (wr) begin
        for (int i = 0; i < 8; i++) if (s[i]) cur[8*i+:8] = d[8*i+:8];
        ref_mem[a] = cur;
      end else e.d = cur;
    end
    return e;
  endfunction

  // slave: mode 0 zero-wait, 1 random, 2 W stalls after AW, 3 AW stalls after W, 4 AW/W never ready
  int mode = 0;
  logic [31:0] rnd = 0;
  logic aw_got = 0, w_got = 0, ar_got = 0;
  logic [31:0] aw_a, ar_a;
  logic [63:0] w_d;
  logic [7:0] w_s;
  int cnt = 0, dly = 0, rdly = 0, aw_beats = 0, w_beats = 0;
  logic [63:0] smem [logic [31:0]];
  assign aw_ready = (mode == 0 || mode == 2) ? 1'b1 : mode == 1 ? rnd[0] :
                    mode == 3 ? (w_got && cnt >= 3) : 1'b0;
  assign w_ready = (mode == 0 || mode == 3) ? 1'b1 : mode == 1 ? rnd[1] :
                   mode == 2 ? (aw_got && cnt >= 3) : 1'b0;
  assign ar_ready = mode == 1 ? rnd[2] : 1'b1;
  always @(posedge clk) begin
    logic [63:0] tmp;
    rnd <= $urandom;
    b_valid <= 0;
    r_valid <= 0;
    if (reset) begin
      aw_got <= 0; w_got <= 0; ar_got <= 0; cnt <= 0;
    end else begin
      if (aw_valid && aw_ready) begin aw_got <= 1; aw_a <= aw_addr; aw_beats <= aw_beats + 1; end
      if (w_valid && w_ready) begin w_got <= 1; w_d <= w_data; w_s <= w_strb; w_beats <= w_beats + 1; end
      if (ar_valid && ar_ready) begin ar_got <= 1; ar_a <= ar_addr; end
      cnt <= (aw_got != w_got) ? cnt + 1 : 0;
      if (aw_got && w_got) begin
        if (dly > 0) dly <= dly - 1;
        else begin
          aw_got <= 0; w_got <= 0; b_valid <= 1; b_resp <= resp_rule(aw_a);
          if (resp_rule(aw_a) == 2'b00) begin
            tmp = smem.exists(aw_a) ? smem[aw_a] : 64'h0;
            for (int i = 0; i < 8; i++) if (w_s[i]) tmp[8*i+:8] = w_d[8*i+:8];
            smem[aw_a] = tmp;
          end
          dly <= mode == 1 ? int'($urandom_range(0, 3)) : 0;
        end
      end
      if (ar_got) begin
        if (rdly > 0) rdly <= rdly - 1;
        else begin
          ar_got <= 0; r_valid <= 1; r_resp <= resp_rule(ar_a);
          r_data <= (resp_rule(ar_a) == 2'b00 && smem.exists(ar_a)) ? smem[ar_a] : 64'h0;
          rdly <= mode == 1 ? int'($urandom_range(0, 3)) : 0;
        end
      end
    end
  end

  bit bp_hold = 0, rsp_rand = 0;
  initial begin
    rsp_ready = 0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = bp_hold ? 1'b0 : rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: scoreboard pops on each response handshake and checks channel stability
  logic pa_v = 0, pa_r = 0, pw_v = 0, pw_r = 0;
  logic [31:0] pa_addr;
  logic [63:0] pw_data;
  rsp_t e;
  always @(negedge clk) begin
    if (reset) begin
      pa_v = 0; pw_v = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_write", rsp_write, e.w);
          chk("rsp_rdata", rsp_rdata, e.d);
          chk("rsp_resp", rsp_resp, e.r);
        end
      end
      if (pa_v && !pa_r) begin chk("aw_hold_valid", aw_valid, 1); chk("aw_hold_addr", aw_addr, pa_addr); end
      if (pw_v && !pw_r) begin chk("w_hold_valid", w_valid, 1); chk("w_hold_data", w_data, pw_data); end
      if (aw_valid) chk("aw_prot", aw_prot, 0);
      if (ar_valid) chk("ar_prot", ar_prot, 0);
      pa_v = aw_valid; pa_r = aw_ready; pa_addr = aw_addr;
      pw_v = w_valid; pw_r = w_ready; pw_data = w_data;
    end
  end

  task automatic send(input bit wr, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                      input bit track);
    int t;
    @(posedge clk); #1;
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (t == 200) chk("req_timeout", req_ready, 1);
    if (track) exp_q.push_back(model(wr, a, d, s));
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (lat >= 200) chk("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic wait_empty();
    int t;
    for (t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    if (t == 300) chk("drain_timeout", rsp_valid, 0);
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                       output int lat);
    send(wr, a, d, s, 1);
    wait_rsp(lat);
    wait_empty();
  endtask

  initial begin
    int lat, b0, w0, t;
    logic [31:0] addrs [5] = '{32'h100, 32'h108, 32'h200, 32'hE000, 32'hD008};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}, 0);
    chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 0);
    chk("rst_payload", {aw_addr, ar_addr, w_data, w_strb}, 0);
    @(posedge clk); #1 reset = 0;

    issue(1, 32'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF, lat);
    chk("wr_latency", lat, 4);
    issue(0, 32'h100, 0, 0, lat);
    chk("rd_latency", lat, 4);
    issue(1, 32'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat);
    issue(1, 32'h200, 64'h0, 8'h0F, lat);
    issue(0, 32'h200, 0, 0, lat);
    chk("partial_model", ref_mem[32'h200], 64'hFFFF_FFFF_0000_0000);

    for (int m = 2; m <= 3; m++) begin
      mode = m; b0 = aw_beats; w0 = w_beats;
      issue(1, 32'h108 + 8 * m, 64'h1234_5678_0000_0000 + m, 8'hFF, lat);
      chk("skew_aw_beats", aw_beats - b0, 1);
      chk("skew_w_beats", w_beats - w0, 1);
    end
    mode = 0;
    issue(0, 32'h118, 0, 0, lat);

    bp_hold = 1;
    send(0, 32'h100, 0, 0, 1);
    wait_rsp(lat);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
      chk("bp_req_ready", req_ready, 0);
    end
    bp_hold = 0;
    wait_empty();
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_ready", req_ready, 1);

    issue(1, 32'hE000, 64'h55, 8'hFF, lat);
    issue(0, 32'hD008, 0, 0, lat);

    mode = 4;
    send(1, 32'h300, 64'hABCD, 8'hFF, 0);
    for (t = 0; t < 20 && !aw_valid; t++) @(negedge clk);
    chk("rst_pre_aw_valid", aw_valid, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("midrst_valids", {aw_valid, w_valid, ar_valid, rsp_valid}, 0);
    chk("midrst_req_ready", req_ready, 1);
    mode = 0;
    issue(0, 32'h100, 0, 0, lat);
    issue(0, 32'h300, 0, 0, lat);

    mode = 1; rsp_rand = 1;
    repeat (40) begin
      issue($urandom_range(0, 1), addrs[$urandom_range(0, 4)], {$urandom, $urandom}, 8'($urandom), lat);
    end
    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
